joy_dir_filter: RTL and testbench
=================================

# joy_dir_filter

Multi-channel joystick direction conditioner placed between the raw player inputs (keyboard/joystick OR) and the core's active-low input ports. It synchronises and debounces every direction bit, then applies a run-time selectable direction policy per channel: pass-through, 4-way last-pressed-wins, 4-way first-held-wins, or 8-way with opposite-direction cleaning. It generalises the existing single-channel one-direction mask to N players, adds debounce, and adds explicit modes with deterministic tie-breaking.

## Interface
- NCH, 2, number of player channels (1..8)
- DEB_W, 8, width of debounce counters and `deb_len`

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  debounce tick enable (e.g. ~1 kHz strobe); counters advance only when high
- mode  in  2  policy: 0 pass, 1 4-way last-wins, 2 4-way first-wins, 3 8-way SOCD-clean
- deb_len  in  DEB_W  ticks a bit must be stable before acceptance; 0 = no debounce
- indir  in  4*NCH  raw directions, channel c at [4c+3:4c] = {up,down,left,right}, active-high, asynchronous
- outdir  out  4*NCH  filtered directions, same packing, registered
- changed  out  NCH  one-cycle pulse when a channel's outdir changes

## Operation
- Per bit: 2-FF synchroniser s1→s2.
- Debounce per bit: deb_len=0 → d <= s2 every clk. Else: if s2==d, cnt<=0; else on ce cnt<=cnt+1, and when cnt+1==deb_len d<=s2, cnt<=0. ce low holds cnt. deb_len change takes effect immediately (cnt ≥ new deb_len: next ce accepts).
- Priority encoder P(v): one-hot of highest set bit, order up(3) > down(2) > left(1) > right(0); P(0)=0.
- rise = d & ~d_prev (d_prev = d delayed one clk).
- Mode 0: out = d; sel held at 0.
- Mode 1: if rise≠0 sel<=P(rise); else if (d&sel)==0 sel<=P(d). out = d & sel_next. Releasing the active direction falls back to a still-held one.
- Mode 2: sel changes only when (d&sel)==0: sel<=P(d). New presses never steal.
- Mode 3: per axis independently. Vertical: if only one of up/down held, pass it; if both, pass the most recently risen; if both rose same cycle, pass neither. Horizontal likewise with left/right. Per-axis last-risen flag register.
- Mode change (mode differs from previous cycle's): sel and axis flags cleared to 0 that cycle; out computed from cleared state.
- changed[c] = (outdir_next[c] != outdir[c]), registered alongside outdir.
- Channels fully independent; no cross-channel state.

## Timing
- Reset (async assert, sync-safe deassert by caller): s1, s2, d, d_prev, cnt, sel, axis flags, outdir, changed all 0.
- Latency with deb_len=0: indir change sampled at edge k → outdir updated at edge k+3 (s1 k, s2 k+1, d k+2, out k+3); changed pulses in the same cycle as outdir changes.
- With deb_len=N: additional N ce ticks after s2 differs from d.
- Reset asserted mid-debounce: counts discarded; after release d starts at 0, so held inputs re-qualify from scratch.
- No handshake; outputs valid every cycle.

## Structure
- Package joy_pkg: mode enum (JOY_PASS, JOY_4_LAST, JOY_4_FIRST, JOY_8_SOCD), direction index constants DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0, priority-encode function.
- Sub-module joy_dir_chan: one channel (sync, debounce, policy, output reg); top generates NCH instances and packs buses.

## Test plan
- deb_len=0, mode 1, ch0: press right, 5 clk later also up → outdir[3:0] 0001 then 1000 at press+3; release up → 0001 (fallback).
- mode 2, same stimulus → stays 0001 while right held; release right with up held → 1000.
- mode 3: hold left, then right → 0001; release right → 0010; up and down rise same cycle → vertical 00; glitch both never 11.
- deb_len=3, ce every 4 clk: 2-tick pulse on indir → no outdir change; pulse held 3 ticks → accepted, changed[0] one cycle high.
- NCH=2: ch0 mode-independent of ch1 stimulus; random indir on ch1 leaves outdir[3:0] and changed[0] constant.
- Reset asserted with inputs held and mode 1 active → all outputs 0 immediately; after release held input reappears after 3 clk (deb_len=0).

Source files
------------

// File: rtl/joy_dir_filter_pkg.sv
// Shared types and helpers for the joystick direction conditioner.
// Direction nibble packing is {up, down, left, right}, active-high.
package joy_pkg;

  typedef enum logic [1:0] {
    JOY_PASS    = 2'd0,
    JOY_4_LAST  = 2'd1,
    JOY_4_FIRST = 2'd2,
    JOY_8_SOCD  = 2'd3
  } joy_mode_e;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // One-hot of the highest-priority set direction: up > down > left > right.
  function automatic logic [3:0] prio_enc(input logic [3:0] v);
    prio_enc = '0;
    if (v[DIR_UP])         prio_enc[DIR_UP]    = 1'b1;
    else if (v[DIR_DOWN])  prio_enc[DIR_DOWN]  = 1'b1;
    else if (v[DIR_LEFT])  prio_enc[DIR_LEFT]  = 1'b1;
    else if (v[DIR_RIGHT]) prio_enc[DIR_RIGHT] = 1'b1;
  endfunction

endpackage

// File: rtl/joy_dir_filter_if.sv
// Control, raw-input and filtered-output bundle of the direction conditioner.
interface joy_dir_filter_if #(
  parameter int NCH   = 2,
  parameter int DEB_W = 8
);
  logic             ce;
  logic [1:0]       mode;
  logic [DEB_W-1:0] deb_len;
  logic [4*NCH-1:0] indir;
  logic [4*NCH-1:0] outdir;
  logic [NCH-1:0]   changed;

  modport master (output ce, mode, deb_len, indir, input outdir, changed);
  modport slave  (input ce, mode, deb_len, indir, output outdir, changed);
endinterface

// File: rtl/joy_dir_filter_chan.sv
// One player channel: 2-FF sync, per-bit debounce, direction policy, output register.
module joy_dir_chan
  import joy_pkg::*;
#(
  parameter int DEB_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  joy_mode_e        mode,
  input  logic [DEB_W-1:0] deb_len,
  input  logic [3:0]       indir,
  output logic [3:0]       outdir,
  output logic             changed
);

  localparam logic [DEB_W:0] ONE = (DEB_W+1)'(1);

  logic [3:0]            s1, s2, d, d_prev, d_next;
  logic [3:0][DEB_W-1:0] cnt, cnt_next;
  logic [DEB_W:0]        inc [4];
  logic [3:0]            sel, sel_next, rise, out_next;
  logic [1:0]            vflag, vflag_next, hflag, hflag_next;
  joy_mode_e             mode_prev;
  logic                  mode_chg;

  // Flag says which member of a pair rose last: 2'b10 upper bit, 2'b01 lower, 00 neither.
  function automatic logic [1:0] flag_upd(input logic [1:0] r, input logic [1:0] f);
    flag_upd = (r == 2'b00) ? f : ((r == 2'b11) ? 2'b00 : r);
  endfunction

  function automatic logic [1:0] socd(input logic [1:0] held, input logic [1:0] f);
    socd = (held == 2'b11) ? f : held;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    d_next   = d;
    cnt_next = cnt;
    for (int b = 0; b < 4; b++) begin
      inc[b] = {1'b0, cnt[b]} + ONE;
      if (deb_len == '0) begin
        d_next[b]   = s2[b];
        cnt_next[b] = '0;
      end else if (s2[b] == d[b]) begin
        cnt_next[b] = '0;
      end else if (ce) begin
        // >= so that shortening deb_len mid-count accepts on the next tick.
        if (inc[b] >= {1'b0, deb_len}) begin
          d_next[b]   = s2[b];
          cnt_next[b] = '0;
        end else begin
          cnt_next[b] = inc[b][DEB_W-1:0];
        end
      end
    end
  end

  assign rise     = d & ~d_prev;
  assign mode_chg = (mode != mode_prev);

  always_comb begin
    sel_next   = sel;
    vflag_next = vflag;
    hflag_next = hflag;
    out_next   = d;
    unique case (mode)
      JOY_PASS:    sel_next = '0;
      JOY_4_LAST: begin
        if (rise != '0)          sel_next = prio_enc(rise);
        else if ((d & sel) == '0) sel_next = prio_enc(d);
      end
      JOY_4_FIRST: if ((d & sel) == '0) sel_next = prio_enc(d);
      JOY_8_SOCD: begin
        vflag_next = flag_upd(rise[DIR_UP:DIR_DOWN], vflag);
        hflag_next = flag_upd(rise[DIR_LEFT:DIR_RIGHT], hflag);
      end
    endcase
    if (mode_chg) begin
      sel_next   = '0;
      vflag_next = '0;
      hflag_next = '0;
    end
    unique case (mode)
      JOY_PASS:                out_next = d;
      JOY_4_LAST, JOY_4_FIRST: out_next = d & sel_next;
      JOY_8_SOCD:              out_next = {socd(d[DIR_UP:DIR_DOWN], vflag_next),
                                           socd(d[DIR_LEFT:DIR_RIGHT], hflag_next)};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: debounce counters are ordinary flops and are reset too, so a reset mid-debounce discards partial counts.
    if (!reset_n) begin
      s1        <= '0;
      s2        <= '0;
      d         <= '0;
      d_prev    <= '0;
      cnt       <= '0;
      sel       <= '0;
      vflag     <= '0;
      hflag     <= '0;
      mode_prev <= JOY_PASS;
      outdir    <= '0;
      changed   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, matching hardware.
      s1        <= indir;
      s2        <= s1;
      d         <= d_next;
      d_prev    <= d;
      cnt       <= cnt_next;
      sel       <= sel_next;
      vflag     <= vflag_next;
      hflag     <= hflag_next;
      mode_prev <= mode;
      outdir    <= out_next;
      changed   <= (out_next != outdir);
    end
  end

endmodule

// File: rtl/joy_dir_filter.sv
// N-channel joystick direction conditioner: one independent joy_dir_chan per player.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEB_W = 8
) (
  input logic             clk,
  input logic             reset_n,
  joy_dir_filter_if.slave jif
);

  logic [3:0] out_arr [NCH];
  logic       chg_arr [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    joy_dir_chan #(.DEB_W(DEB_W)) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (jif.ce),
      .mode    (joy_mode_e'(jif.mode)),
      .deb_len (jif.deb_len),
      .indir   (jif.indir[4*c +: 4]),
      .outdir  (out_arr[c]),
      .changed (chg_arr[c])
    );
  end

  always_comb begin
    jif.outdir  = '0;
    jif.changed = '0;
    for (int c = 0; c < NCH; c++) begin
      jif.outdir[4*c +: 4] = out_arr[c];
      jif.changed[c]       = chg_arr[c];
    end
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_joy_dir_filter;
  import joy_pkg::*;

  localparam int NCH   = 2;
  localparam int DEB_W = 8;

  logic clk = 1'b0;
  logic reset_n;

  joy_dir_filter_if #(.NCH(NCH), .DEB_W(DEB_W)) jif ();

  joy_dir_filter #(.NCH(NCH), .DEB_W(DEB_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .jif     (jif)
  );

  initial forever #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  bit chk_en    = 1'b0;
  bit ce_en     = 1'b0;
  int ce_phase  = 0;
  int chg_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int c, input logic [3:0] v);
    jif.indir[4*c +: 4] = v;
  endtask

  // Behavioural model: integer active-direction index and per-axis "last riser" ids.
  logic [3:0] m_s1 [NCH], m_s2 [NCH], m_d [NCH], m_dp [NCH], m_out [NCH];
  logic       m_chg [NCH];
  int         m_cnt [NCH][4];
  int         m_act [NCH], m_vl [NCH], m_hl [NCH];
  int         m_mprev;

  function automatic int highest(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit is_held(input logic [3:0] v, input int i);
    if (i < 0) return 1'b0;
    return v[i];
  endfunction

  // Resolve one axis: hi/lo held bits, last = 1 hi rose last, 2 lo rose last, 0 neither.
  function automatic logic [1:0] axis_out(input logic hi, input logic lo, input int last);
    if (hi && lo) return {last == 1, last == 2};
    return {hi, lo};
  endfunction

  function automatic int axis_last(input logic rhi, input logic rlo, input int last);
    if (rhi && rlo) return 0;
    if (rhi) return 1;
    if (rlo) return 2;
    return last;
  endfunction

  task automatic model_step();
    logic [3:0] dd, rose, nd, o;
    bit mchg;
    int md, act;
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_s1[c] = '0; m_s2[c] = '0; m_d[c] = '0; m_dp[c] = '0; m_out[c] = '0;
        m_chg[c] = 1'b0; m_act[c] = -1; m_vl[c] = 0; m_hl[c] = 0;
        for (int b = 0; b < 4; b++) m_cnt[c][b] = 0;
      end
      m_mprev = 0;
      return;
    end
    md   = int'(jif.mode);
    mchg = (md != m_mprev);
    for (int c = 0; c < NCH; c++) begin
      dd   = m_d[c];
      rose = dd & ~m_dp[c];
      nd   = dd;
      for (int b = 0; b < 4; b++) begin
        if (jif.deb_len == 0) begin
          nd[b] = m_s2[c][b];
          m_cnt[c][b] = 0;
        end else if (m_s2[c][b] == dd[b]) begin
          m_cnt[c][b] = 0;
        end else if (jif.ce) begin
          if (m_cnt[c][b] + 1 >= int'(jif.deb_len)) begin
            nd[b] = m_s2[c][b];
            m_cnt[c][b] = 0;
          end else begin
            m_cnt[c][b]++;
          end
        end
      end
      act = m_act[c];
      if (mchg) begin
        act = -1; m_vl[c] = 0; m_hl[c] = 0;
      end else begin
        case (md)
          0: act = -1;
          1: if (rose != 0) act = highest(rose);
             else if (!is_held(dd, act)) act = highest(dd);
          2: if (!is_held(dd, act)) act = highest(dd);
          default: begin
            m_vl[c] = axis_last(rose[3], rose[2], m_vl[c]);
            m_hl[c] = axis_last(rose[1], rose[0], m_hl[c]);
          end
        endcase
      end
      o = '0;
      case (md)
        0: o = dd;
        1, 2: if (is_held(dd, act)) o[act[1:0]] = 1'b1;
        default: o = {axis_out(dd[3], dd[2], m_vl[c]), axis_out(dd[1], dd[0], m_hl[c])};
      endcase
      m_chg[c] = (o != m_out[c]);
      m_out[c] = o;
      m_act[c] = act;
      m_dp[c]  = dd;
      m_d[c]   = nd;
      m_s2[c]  = m_s1[c];
      m_s1[c]  = jif.indir[4*c +: 4];
    end
    m_mprev = md;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("model_outdir_ch%0d", c), 32'(jif.outdir[4*c +: 4]), 32'(m_out[c]));
        check($sformatf("model_changed_ch%0d", c), 32'(jif.changed[c]), 32'(m_chg[c]));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    ce_phase++;
    jif.ce = ce_en && (ce_phase % 4 == 0);
    if (jif.changed[0]) chg_count++;
  end

  initial begin
    reset_n     = 1'b0;
    jif.indir   = '0;
    jif.mode    = JOY_4_LAST;
    jif.deb_len = '0;
    jif.ce      = 1'b0;
    tick(3);
    check("reset_outdir", 32'(jif.outdir), 32'h0);
    check("reset_changed", 32'(jif.changed), 32'h0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    tick(3);

    // Mode 1: last pressed wins, fallback to a still-held direction.
    set_ch(0, 4'b0001);
    tick(3); check("m1_latency_k2", 32'(jif.outdir[3:0]), 32'h0);
    tick(1); check("m1_right", 32'(jif.outdir[3:0]), 32'b0001);
    check("m1_changed_pulse", 32'(jif.changed[0]), 32'h1);
    tick(1); check("m1_changed_low", 32'(jif.changed[0]), 32'h0);
    set_ch(0, 4'b1001);
    tick(4); check("m1_up_steals", 32'(jif.outdir[3:0]), 32'b1000);
    set_ch(0, 4'b0001);
    tick(4); check("m1_fallback", 32'(jif.outdir[3:0]), 32'b0001);
    set_ch(0, 4'b0000);
    tick(4); check("m1_release", 32'(jif.outdir[3:0]), 32'h0);

    // Mode 2: first held wins.
    jif.mode = JOY_4_FIRST;
    tick(2);
    set_ch(0, 4'b0001);
    tick(4); check("m2_right", 32'(jif.outdir[3:0]), 32'b0001);
    set_ch(0, 4'b1001);
    tick(6); check("m2_no_steal", 32'(jif.outdir[3:0]), 32'b0001);
    set_ch(0, 4'b1000);
    tick(4); check("m2_handover", 32'(jif.outdir[3:0]), 32'b1000);
    set_ch(0, 4'b0000);
    tick(4);

    // Mode 3: SOCD cleaning per axis.
    jif.mode = JOY_8_SOCD;
    tick(2);
    set_ch(0, 4'b0010);
    tick(4); check("m3_left", 32'(jif.outdir[3:0]), 32'b0010);
    set_ch(0, 4'b0011);
    tick(4); check("m3_right_last", 32'(jif.outdir[3:0]), 32'b0001);
    set_ch(0, 4'b0010);
    tick(4); check("m3_back_left", 32'(jif.outdir[3:0]), 32'b0010);
    set_ch(0, 4'b0000);
    tick(4);
    set_ch(0, 4'b1100);
    tick(4); check("m3_same_cycle", 32'(jif.outdir[3:0]), 32'h0);
    for (int i = 0; i < 24; i++) begin
      set_ch(0, {2'($urandom_range(0, 3)), 2'b00});
      tick(1);
      check("m3_never_11", 32'(jif.outdir[3:2] == 2'b11), 32'h0);
    end
    set_ch(0, 4'b0000);
    tick(4);

    // Debounce: deb_len=3, ce every 4 clk.
    jif.mode    = JOY_PASS;
    jif.deb_len = 8'd3;
    ce_en       = 1'b1;
    tick(8);
    chg_count = 0;
    set_ch(0, 4'b0001);
    tick(8);
    set_ch(0, 4'b0000);
    tick(12);
    check("deb_short_out", 32'(jif.outdir[3:0]), 32'h0);
    check("deb_short_chg", 32'(chg_count), 32'h0);
    chg_count = 0;
    set_ch(0, 4'b0001);
    tick(12);
    set_ch(0, 4'b0000);
    tick(6);
    check("deb_accept_out", 32'(jif.outdir[3:0]), 32'b0001);
    check("deb_accept_chg", 32'(chg_count), 32'h1);
    tick(20);
    check("deb_release_out", 32'(jif.outdir[3:0]), 32'h0);
    check("deb_release_chg", 32'(chg_count), 32'h2);
    ce_en       = 1'b0;
    jif.deb_len = '0;
    tick(4);

    // Channel independence: random ch1 must not disturb ch0.
    jif.mode = JOY_4_LAST;
    set_ch(0, 4'b0001);
    tick(6);
    check("x_ch0_held", 32'(jif.outdir[3:0]), 32'b0001);
    for (int i = 0; i < 40; i++) begin
      set_ch(1, 4'($urandom_range(0, 15)));
      tick(1);
      check("x_ch0_out", 32'(jif.outdir[3:0]), 32'b0001);
      check("x_ch0_chg", 32'(jif.changed[0]), 32'h0);
    end
    set_ch(1, 4'b0000);
    tick(6);

    // Reset with held input in mode 1.
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_out", 32'(jif.outdir), 32'h0);
    check("rst_async_chg", 32'(jif.changed), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(3); check("rst_relatch_k2", 32'(jif.outdir[3:0]), 32'h0);
    tick(1); check("rst_relatch_k3", 32'(jif.outdir[3:0]), 32'b0001);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
